// File: rtl/demux1to8_deser_if.sv
// Bus bundle for demux1to8_deser: serial input side, parallel output side,
// and the slot / fragment status outputs.
// Optional macro DEMUX1TO8_PARITY_EN adds the out_parity signal.
// The DUT uses the slave modport and the bit source / word sink uses master.
interface demux1to8_deser_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
);
    logic             din;
    logic             din_valid;
    logic             din_sync;
    logic             din_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [SEL_W-1:0] slot;
    logic [7:0]       frag_cnt;
`ifdef DEMUX1TO8_PARITY_EN
    logic             out_parity;
`endif

    modport master (
        output din, din_valid, din_sync, out_ready,
`ifdef DEMUX1TO8_PARITY_EN
        input  out_parity,
`endif
        input  din_ready, out_data, out_valid, slot, frag_cnt
    );

    modport slave (
        input  din, din_valid, din_sync, out_ready,
`ifdef DEMUX1TO8_PARITY_EN
        output out_parity,
`endif
        output din_ready, out_data, out_valid, slot, frag_cnt
    );
endinterface

// File: rtl/demux1to8_deser.sv
// demux1to8_deser: rebuilds a serial stream into parallel words.
// A slot counter works as the demux select. It steers each accepted bit into
// data_q[slot]. A finished word waits in HOLD until the consumer takes it.
// A din_sync bit restarts the word at slot 0. Any partial word it drops is
// counted in a saturating fragment counter.
// Optional macro DEMUX1TO8_PARITY_EN adds out_parity. The parity is built up
// one bit at a time while the word fills.
// Reset is asynchronous and active high. Release of rst must be synchronous
// to clk.
module demux1to8_deser #(
    parameter int WIDTH = 8,   // must equal 2**SEL_W
    parameter int SEL_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    demux1to8_deser_if.slave   bus
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] SLOT_ZERO = SEL_W'(0);
    localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SLOT_LAST = SEL_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};
    localparam logic [7:0]       FRAG_MAX  = 8'hFF;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] slot_q, slot_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       frag_cnt_q, frag_cnt_d;
    logic [WIDTH-1:0] word_s;
    logic             din_ready_s;
    logic             accept_s;
`ifdef DEMUX1TO8_PARITY_EN
    logic             par_acc_q, par_acc_d;
    logic             out_parity_q, out_parity_d;
`endif

    // Start a new word whose only bit is b, placed in slot 0.
    function automatic logic [WIDTH-1:0] first_bit(input logic b);
        logic [WIDTH-1:0] w;
        w    = WORD_ZERO;
        w[0] = b;
        return w;
    endfunction

    // Add one to the fragment counter, but never go past 255.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        if (c == FRAG_MAX) begin
            return c;
        end else begin
            return c + 8'd1;
        end
    endfunction

    // Fold one more serial bit into the running parity.
    function automatic logic par_step(input logic acc, input logic b);
        return acc ^ b;
    endfunction

    // Next-state logic: handshake, slot steering, word completion and handoff.
    always_comb begin
        din_ready_s = (state_q == FILL) || bus.out_ready;
        accept_s    = bus.din_valid && din_ready_s;
        state_d     = state_q;
        slot_d      = slot_q;
        data_d      = data_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        frag_cnt_d  = frag_cnt_q;
        word_s      = data_q;
        word_s[slot_q] = bus.din;
`ifdef DEMUX1TO8_PARITY_EN
        par_acc_d    = par_acc_q;
        out_parity_d = out_parity_q;
`endif
        case (state_q)
            FILL: begin
                if (accept_s) begin
                    if (bus.din_sync) begin
                        // Resynchronise. Anything gathered so far is a fragment.
                        data_d = first_bit(bus.din);
                        slot_d = SLOT_ONE;
                        if (slot_q != SLOT_ZERO) begin
                            frag_cnt_d = sat_inc(frag_cnt_q);
                        end else begin
                            frag_cnt_d = frag_cnt_q;
                        end
`ifdef DEMUX1TO8_PARITY_EN
                        par_acc_d = bus.din;
`endif
                    end else begin
                        data_d = word_s;
`ifdef DEMUX1TO8_PARITY_EN
                        par_acc_d = par_step(par_acc_q, bus.din);
`endif
                        if (slot_q == SLOT_LAST) begin
                            // The last bit completes the word. Present it next cycle.
                            slot_d      = SLOT_ZERO;
                            state_d     = HOLD;
                            out_valid_d = 1'b1;
                            out_data_d  = word_s;
`ifdef DEMUX1TO8_PARITY_EN
                            out_parity_d = par_step(par_acc_q, bus.din);
                            par_acc_d    = 1'b0;
`endif
                        end else begin
                            slot_d = slot_q + SLOT_ONE;
                        end
                    end
                end else begin
                    data_d = data_q;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    // The word is handed off. A bit arriving now starts the next word.
                    state_d     = FILL;
                    out_valid_d = 1'b0;
                    out_data_d  = WORD_ZERO;
`ifdef DEMUX1TO8_PARITY_EN
                    out_parity_d = 1'b0;
`endif
                    if (accept_s) begin
                        data_d = first_bit(bus.din);
                        slot_d = SLOT_ONE;
`ifdef DEMUX1TO8_PARITY_EN
                        par_acc_d = bus.din;
`endif
                    end else begin
                        data_d = WORD_ZERO;
                        slot_d = SLOT_ZERO;
`ifdef DEMUX1TO8_PARITY_EN
                        par_acc_d = 1'b0;
`endif
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d     = FILL;
                slot_d      = SLOT_ZERO;
                data_d      = WORD_ZERO;
                out_data_d  = WORD_ZERO;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers. Async reset clears everything, including any held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            slot_q      <= SLOT_ZERO;
            data_q      <= WORD_ZERO;
            out_data_q  <= WORD_ZERO;
            out_valid_q <= 1'b0;
            frag_cnt_q  <= 8'h00;
`ifdef DEMUX1TO8_PARITY_EN
            par_acc_q    <= 1'b0;
            out_parity_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            data_q      <= data_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frag_cnt_q  <= frag_cnt_d;
`ifdef DEMUX1TO8_PARITY_EN
            par_acc_q    <= par_acc_d;
            out_parity_q <= out_parity_d;
`endif
        end
    end

    assign bus.din_ready = din_ready_s;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.slot      = slot_q;
    assign bus.frag_cnt  = frag_cnt_q;
`ifdef DEMUX1TO8_PARITY_EN
    assign bus.out_parity = out_parity_q;
`endif

endmodule
